// File: rtl/window_gen_3x3_if.sv
// Pixel-in / window-out bundle for the 3x3 neighbourhood generator.
// The slave modport is the generator itself; the master modport is the
// frame source that feeds pixels and consumes the nine taps.
interface window_gen_3x3_if #(
   parameter int XW = 9,
   parameter int YW = 8
);
   logic [7:0]    pix_in;
   logic          pix_valid;
   logic          sof;
   logic [7:0]    ar11, ar12, ar13;
   logic [7:0]    ar21, ar22, ar23;
   logic [7:0]    ar31, ar32, ar33;
   logic          win_valid;
   logic [XW-1:0] win_x;
   logic [YW-1:0] win_y;
   logic          frame_end;

   modport master (
      output pix_in, pix_valid, sof,
      input  ar11, ar12, ar13, ar21, ar22, ar23, ar31, ar32, ar33,
      input  win_valid, win_x, win_y, frame_end
   );

   modport slave (
      input  pix_in, pix_valid, sof,
      output ar11, ar12, ar13, ar21, ar22, ar23, ar31, ar32, ar33,
      output win_valid, win_x, win_y, frame_end
   );
endinterface

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 window generator: two line buffers hold the previous two
// rows, a 3x3 register array shifts in one new column per accepted pixel,
// and border windows are never flagged valid.
module window_gen_3x3 #(
   parameter int IMG_W = 320,
   parameter int IMG_H = 240,
   parameter int XW    = $clog2(IMG_W),
   parameter int YW    = $clog2(IMG_H)
) (
   input  logic             clk,
   input  logic             rst_n,
   window_gen_3x3_if.slave  bus
);

   localparam logic [XW-1:0] LAST_X = XW'(IMG_W - 1);
   localparam logic [YW-1:0] LAST_Y = YW'(IMG_H - 1);

   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [XW-1:0] cur_x;
   logic [YW-1:0] cur_y;
   logic [7:0]    lb0 [IMG_W];
   logic [7:0]    lb1 [IMG_W];
   logic [7:0]    lb0_rd;
   logic [7:0]    lb1_rd;

   // A start-of-frame pixel is always (0,0), whatever the counters say.
   assign cur_x  = bus.sof ? '0 : x;
   assign cur_y  = bus.sof ? '0 : y;
   assign lb0_rd = lb0[cur_x];
   assign lb1_rd = lb1[cur_x];

   // Raster counters: advance on every accepted pixel, wrap at frame end.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x <= '0;
         y <= '0;
      end else if (bus.pix_valid) begin
         if (cur_x == LAST_X) begin
            x <= '0;
            y <= (cur_y == LAST_Y) ? '0 : cur_y + YW'(1);
         end else begin
            x <= cur_x + XW'(1);
            y <= cur_y;
         end
      end
   end

   // Line buffers: row y-1 moves down to the y-2 buffer as the new pixel lands.
   always_ff @(posedge clk) begin
      if (bus.pix_valid) begin
         lb1[cur_x] <= lb0_rd;
         lb0[cur_x] <= bus.pix_in;
      end
   end

   // Window registers: shift columns left and load the freshly read column.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.ar11 <= '0; bus.ar12 <= '0; bus.ar13 <= '0;
         bus.ar21 <= '0; bus.ar22 <= '0; bus.ar23 <= '0;
         bus.ar31 <= '0; bus.ar32 <= '0; bus.ar33 <= '0;
      end else if (bus.pix_valid) begin
         bus.ar11 <= bus.ar12; bus.ar12 <= bus.ar13; bus.ar13 <= lb1_rd;
         bus.ar21 <= bus.ar22; bus.ar22 <= bus.ar23; bus.ar23 <= lb0_rd;
         bus.ar31 <= bus.ar32; bus.ar32 <= bus.ar33; bus.ar33 <= bus.pix_in;
      end
   end

   // Qualify complete windows, track the centre coordinate and flag frame end.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.win_valid <= 1'b0;
         bus.win_x     <= '0;
         bus.win_y     <= '0;
         bus.frame_end <= 1'b0;
      end else begin
         bus.win_valid <= 1'b0;
         bus.frame_end <= 1'b0;
         if (bus.pix_valid) begin
            if (cur_x >= XW'(2) && cur_y >= YW'(2)) begin
               bus.win_valid <= 1'b1;
               bus.win_x     <= cur_x - XW'(1);
               bus.win_y     <= cur_y - YW'(1);
            end
            bus.frame_end <= (cur_x == LAST_X) && (cur_y == LAST_Y);
         end
      end
   end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3 on a 5x4 frame with pixel = base+10*y+x.
module tb_window_gen_3x3;

   localparam int W  = 5;
   localparam int H  = 4;
   localparam int XW = 3;
   localparam int YW = 2;

   logic clk;
   logic rst_n;
   int   compared;
   int   mismatched;
   logic [7:0] lastPix;

   window_gen_3x3_if #(.XW(XW), .YW(YW)) bus ();

   window_gen_3x3 #(.IMG_W(W), .IMG_H(H), .XW(XW), .YW(YW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [7:0] tap [9];
   assign tap[0] = bus.ar11; assign tap[1] = bus.ar12; assign tap[2] = bus.ar13;
   assign tap[3] = bus.ar21; assign tap[4] = bus.ar22; assign tap[5] = bus.ar23;
   assign tap[6] = bus.ar31; assign tap[7] = bus.ar32; assign tap[8] = bus.ar33;

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      compared++;
      if (observed != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs and return #1 after the capturing edge.
   task automatic applyStimulus(input logic [7:0] pix, input logic valid, input logic sofIn);
      bus.pix_in    = pix;
      bus.pix_valid = valid;
      bus.sof       = sofIn;
      @(posedge clk);
      #1;
      if (valid) lastPix = pix;
   endtask

   task automatic checkWindow(input int base, input int cx, input int cy);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            checkOutput($sformatf("tap%0d%0d@%0d,%0d", r + 1, c + 1, cx, cy),
                        int'(tap[r*3+c]), base + 10 * (cy - 1 + r) + (cx - 1 + c));
      checkOutput("win_x", int'(bus.win_x), cx);
      checkOutput("win_y", int'(bus.win_y), cy);
   endtask

   // Stream one full frame, optionally with an idle cycle after each pixel.
   task automatic sendFrame(input int base, input bit gaps, input bit useSof);
      int winCount;
      winCount = 0;
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            applyStimulus(8'(base + 10 * y + x), 1'b1, useSof && x == 0 && y == 0);
            checkOutput($sformatf("win_valid@%0d,%0d", x, y), int'(bus.win_valid),
                        int'(x >= 2 && y >= 2));
            checkOutput($sformatf("frame_end@%0d,%0d", x, y), int'(bus.frame_end),
                        int'(x == W - 1 && y == H - 1));
            if (bus.win_valid) winCount++;
            if (x >= 2 && y >= 2) checkWindow(base, x - 1, y - 1);
            if (gaps) begin
               applyStimulus(8'hEE, 1'b0, 1'b0);
               checkOutput("gap_win_valid", int'(bus.win_valid), 0);
               checkOutput("gap_frame_end", int'(bus.frame_end), 0);
               checkOutput("gap_ar33_hold", int'(bus.ar33), base + 10 * y + x);
               if (x >= 2 && y >= 2) checkWindow(base, x - 1, y - 1);
            end
         end
      end
      checkOutput("win_count", winCount, (W - 2) * (H - 2));
   endtask

   // Stream only the first n pixels of a frame; none of them may finish a window.
   task automatic sendPartial(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(8'(base + 10 * (i / W) + (i % W)), 1'b1, i == 0);
         checkOutput("partial_win_valid", int'(bus.win_valid), 0);
         checkOutput("partial_frame_end", int'(bus.frame_end), 0);
      end
   endtask

   task automatic checkResetState(input string tag);
      for (int i = 0; i < 9; i++)
         checkOutput($sformatf("%s_tap%0d", tag, i), int'(tap[i]), 0);
      checkOutput({tag, "_win_valid"}, int'(bus.win_valid), 0);
      checkOutput({tag, "_win_x"}, int'(bus.win_x), 0);
      checkOutput({tag, "_win_y"}, int'(bus.win_y), 0);
      checkOutput({tag, "_frame_end"}, int'(bus.frame_end), 0);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      lastPix    = '0;
      rst_n         = 1'b0;
      bus.pix_in    = '0;
      bus.pix_valid = 1'b0;
      bus.sof       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkResetState("reset");
      rst_n = 1'b1;

      $display("[TB] continuous frame");
      sendFrame(0, 1'b0, 1'b1);

      $display("[TB] frame with idle gaps");
      sendFrame(0, 1'b1, 1'b1);

      $display("[TB] back-to-back frames");
      sendFrame(0, 1'b0, 1'b1);
      sendFrame(100, 1'b0, 1'b1);

      $display("[TB] sof resync mid-frame");
      sendPartial(0, 8);
      sendFrame(200, 1'b0, 1'b1);

      $display("[TB] reset mid-frame");
      sendPartial(0, 9);
      checkOutput("pre_reset_ar33", int'(bus.ar33), 13);
      rst_n         = 1'b0;
      bus.pix_valid = 1'b0;
      @(posedge clk);
      #1;
      checkResetState("midreset");
      rst_n = 1'b1;
      sendFrame(50, 1'b0, 1'b0);

      applyStimulus(8'h00, 1'b0, 1'b0);
      checkOutput("idle_win_valid", int'(bus.win_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/window_gen_3x3.md
Name: window_gen_3x3

Overview:
- Streaming 3x3 neighbourhood generator that sits directly upstream of the edge kernel.
- Accepts one raster-order 8-bit greyscale pixel per valid cycle from the frame source (BRAM reader or camera path).
- Uses two internal line buffers plus a 3x3 register window to present the nine taps ar11..ar33 to the kernel, with a qualifying valid and centre coordinates.
- Border windows (incomplete neighbourhoods) are never flagged valid.

Parameters:
- IMG_W, 320, pixels per line (>=3).
- IMG_H, 240, lines per frame (>=3).
- XW, $clog2(IMG_W), width of x counter/coordinate.
- YW, $clog2(IMG_H), width of y counter/coordinate.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- pix_in  in  8  incoming pixel, sampled when pix_valid=1.
- pix_valid  in  1  pixel strobe; no backpressure, every strobed pixel is consumed.
- sof  in  1  start of frame, qualified by pix_valid; marks the pixel as (0,0).
- ar11,ar12,ar13,ar21,ar22,ar23,ar31,ar32,ar33  out  8 each  window taps; arRC, R=1 oldest row, C=1 oldest column.
- win_valid  out  1  taps form a complete 3x3 window this cycle.
- win_x  out  XW  column of centre tap ar22.
- win_y  out  YW  row of centre tap ar22.
- frame_end  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (rst_n=0 at clk edge): all outputs 0, x=y=0. Line buffer RAM is not cleared; stale contents are masked by valid gating.
- Counters advance only on pix_valid=1.
  - x wraps at IMG_W-1 to 0 and y increments.
  - At (IMG_W-1, IMG_H-1), x and y wrap to (0,0).
- sof=1 with pix_valid=1: that pixel is treated as (0,0) regardless of the counters; the counters continue from (1,0). Resync is allowed mid-frame.
- Line buffers: lb0 holds row y-1 and lb1 holds row y-2, each IMG_W deep, addressed by x. Read is asynchronous and read-before-write within the same cycle.
- On each accepted pixel at (x,y), the registers update as follows:
  - Column shift: arR1<=arR2, arR2<=arR3.
  - New column: ar33<=pix_in, ar23<=lb0[x], ar13<=lb1[x].
  - Line buffer writes: lb1[x]<=lb0[x], lb0[x]<=pix_in.
- win_valid is registered. It is set to 1 in the cycle after accepting a pixel with x>=2 and y>=2; otherwise it is set to 0. win_valid is 0 in any cycle following pix_valid=0.
  - In that same cycle, win_x<=x-1 and win_y<=y-1.
- Latency: pixel at (x,y) strobed at edge N completes window centre (x-1,y-1), presented after edge N+1.
- pix_valid=0: taps, win_x and win_y hold their values; win_valid=0; counters and RAM are unchanged.
- Windows never straddle lines. At x=0 and x=1 the shift register carries the previous line's tail, and win_valid stays 0.
- Window count per frame is exactly (IMG_W-2)*(IMG_H-2).
- frame_end: registered, 1 in the cycle after accepting (IMG_W-1, IMG_H-1), coincident with the last win_valid. It is not asserted when sof forces an early wrap.
- Reset mid-frame aborts the frame. No win_valid is produced until two full lines of the new stream have been accepted.

Test Plan:
- IMG_W=5, IMG_H=4, pixel=10*y+x, continuous pix_valid, sof on the first pixel -> first win_valid the cycle after pixel 22. Taps: ar11..ar13=0,1,2; ar21..ar23=10,11,12; ar31..ar33=20,21,22. win_x=1, win_y=1.
- Same frame -> exactly 6 win_valid pulses; the last has ar33=34, win_x=3, win_y=2, with frame_end=1 in the same cycle.
- Same frame with pix_valid toggling 1,0,1,0 -> identical 6 windows and values. win_valid is never high in a cycle after pix_valid=0, and taps hold during gaps.
- Two back-to-back frames, second frame pixel=100+10*y+x -> the second frame's first window has ar11=100 and ar33=122. No window mixes frame-1 data.
- sof asserted at frame-1 pixel (3,1) -> counters resync so that this pixel is (0,0). No win_valid until the pixel at y=2,x=2 relative to the resync; no frame_end from the aborted frame.
- rst_n low one cycle after pixel 13 -> all outputs 0 next cycle. The restarted frame yields exactly 6 valid windows with correct new-frame taps.
